// File: rtl/sha1_pkg.sv
// Shared types, constants and round helpers for the SHA-1 compression engine.
package sha1_pkg;
  localparam int ROUNDS = 80;
  localparam int WORDS  = 16;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // H0 sits in the low word so digest[32i+31:32i] is H_i.
  localparam logic [4:0][31:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                     32'hEFCDAB89, 32'h67452301};

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] k_t(input logic [6:0] t);
    if (t < 7'd20)      return K0;
    else if (t < 7'd40) return K1;
    else if (t < 7'd60) return K2;
    else                return K3;
  endfunction

  function automatic logic [31:0] f_t(input logic [6:0] t, input logic [31:0] b, c, d);
    if (t < 7'd20)                     return (b & c) | (~b & d);
    else if (t < 7'd40 || t >= 7'd60)  return b ^ c ^ d;
    else                               return (b & c) | (b & d) | (c & d);
  endfunction
endpackage

// File: rtl/sha1_if.sv
// Control/data bundle between the register front-end and the compression core.
interface sha1_if;
  logic                             start;
  logic                             chain;
  logic                             abort;
  logic [sha1_pkg::WORDS*32-1:0]    message;
  logic [159:0]                     digest;
  logic                             busy;
  logic                             done;
  logic                             panic;
  logic [6:0]                       loop_idx;

  modport master (output start, chain, abort, message,
                  input  digest, busy, done, panic, loop_idx);
  modport slave  (input  start, chain, abort, message,
                  output digest, busy, done, panic, loop_idx);
endinterface

// File: rtl/sha1_w_sched.sv
// 16-word sliding message schedule: w_t is always the word for the current round.
module sha1_w_sched import sha1_pkg::rotl; #(
  parameter int WORDS = 16
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [WORDS*32-1:0]   message,
  output logic [31:0]           w_t
);
  logic [WORDS-1:0][31:0] win;
  logic [31:0]            w_next;

  // win[0] holds W[t], so W[t+16] draws on offsets 13, 8, 2 and 0.
  assign w_next = rotl(win[WORDS-3] ^ win[WORDS-8] ^ win[WORDS-14] ^ win[0], 1);
  assign w_t    = win[0];

  always_ff @(posedge gclk) begin
    if (!grst_n)      win <= '0;
    else if (load)    win <= message;
    else if (advance) win <= {w_next, win[WORDS-1:1]};
  end
endmodule

// File: rtl/sha1_core.sv
// SHA-1 compression engine: one round per clock, chaining digest, status for the front-end.
module sha1_core import sha1_pkg::*; (
  input logic   wb_clk_i,
  input logic   reset_n,
  sha1_if.slave bus
);
  state_t           state;
  logic [4:0][31:0] wk;     // wk[0]=a .. wk[4]=e
  logic [4:0][31:0] h;
  logic [4:0][31:0] hash;
  logic [4:0][31:0] h_in;
  logic [4:0][31:0] sum;
  logic [31:0]      w_t;
  logic [31:0]      temp;
  logic [6:0]       loop_idx;
  logic             busy, done, panic, accept;

  assign accept = bus.start && !bus.abort && (state == IDLE || state == DONE);
  assign h_in   = bus.chain ? hash : IV;
  assign temp   = rotl(wk[0], 5) + f_t(loop_idx, wk[1], wk[2], wk[3]) + wk[4]
                + k_t(loop_idx) + w_t;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 5; i++) sum[i] = h[i] + wk[i];
  end

  sha1_w_sched #(.WORDS(WORDS)) u_wsched (
    .gclk    (wb_clk_i),
    .grst_n  (reset_n),
    .load    (accept),
    .advance (state == ROUND),
    .message (bus.message),
    .w_t     (w_t)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state <= IDLE; hash <= '0; h <= '0; wk <= '0;
      done <= 1'b0; busy <= 1'b0; panic <= 1'b0; loop_idx <= '0;
    end else if (bus.abort) begin
      state <= IDLE; done <= 1'b0; busy <= 1'b0; panic <= 1'b0; loop_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          h <= h_in; wk <= h_in; loop_idx <= '0;
          done <= 1'b0; busy <= 1'b1; panic <= 1'b0; state <= ROUND;
        end
        ROUND: begin
          if (bus.start) panic <= 1'b1;
          wk <= {wk[3], wk[2], rotl(wk[1], 30), wk[0], temp};
          // loop_idx parks at the last round while FINAL folds the digest.
          if (loop_idx == 7'(ROUNDS - 1)) state <= FINAL;
          else                            loop_idx <= loop_idx + 7'd1;
        end
        FINAL: begin
          if (bus.start) panic <= 1'b1;
          hash <= sum; done <= 1'b1; busy <= 1'b0; loop_idx <= '0; state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digest   = hash;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.panic    = panic;
  assign bus.loop_idx = loop_idx;
endmodule

// File: tb/tb_sha1_core.sv
// Self-checking bench for sha1_core: vector table plus reference model and corner sequences.
module tb_sha1_core;
  logic wb_clk_i = 1'b0;
  logic reset_n  = 1'b0;
  sha1_if bus();

  sha1_core dut (.wb_clk_i(wb_clk_i), .reset_n(reset_n), .bus(bus));

  always #5 wb_clk_i = ~wb_clk_i;

  localparam logic [159:0] IV_C  = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
  localparam logic [159:0] ABC_D = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
  localparam logic [159:0] TWO_D = {32'he54670f1, 32'hf95129e5, 32'hbaae4aa1, 32'h1c3bd26e, 32'h84983e44};

  typedef struct {
    logic [511:0] msg;
    logic         chain;
    logic [159:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SHA-1 compression over a full 80-word schedule.
  function automatic logic [159:0] ref_compress(input logic [159:0] hin, input logic [511:0] m);
    logic [31:0]  w [80];
    logic [31:0]  v [5];
    logic [31:0]  f, k, tmp;
    logic [159:0] res;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = m[32*t +: 32];
      else        w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    end
    for (int i = 0; i < 5; i++) v[i] = hin[32*i +: 32];
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin f = (v[1] & v[2]) | (~v[1] & v[3]);               k = 32'h5A827999; end
        1:       begin f = v[1] ^ v[2] ^ v[3];                            k = 32'h6ED9EBA1; end
        2:       begin f = (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]); k = 32'h8F1BBCDC; end
        default: begin f = v[1] ^ v[2] ^ v[3];                            k = 32'hCA62C1D6; end
      endcase
      tmp  = rl(v[0], 5) + f + v[4] + k + w[t];
      v[4] = v[3]; v[3] = v[2]; v[2] = rl(v[1], 30); v[1] = v[0]; v[0] = tmp;
    end
    for (int i = 0; i < 5; i++) res[32*i +: 32] = hin[32*i +: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
    return m;
  endfunction

  // Runs one block from the negedge before the start edge to the first cycle with done high.
  task automatic run_block(input logic [511:0] msg, input logic ch, input int inject_at,
                           input string tag, output logic [159:0] dg);
    int lat, busy_cnt, idx_bad;
    @(negedge wb_clk_i);
    bus.message = msg; bus.chain = ch; bus.start = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b0; bus.message = ~msg; bus.chain = ~ch;
    lat = 0; busy_cnt = 0; idx_bad = 0;
    while (!bus.done && lat < 200) begin
      if (lat == 0) check({tag, "_panic_clr"}, {159'd0, bus.panic}, 160'd0);
      if (bus.busy) busy_cnt++;
      if (lat < 80 && bus.loop_idx != 7'(lat)) idx_bad++;
      bus.start = (lat == inject_at);
      @(negedge wb_clk_i);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"},  160'(lat),      160'd81);
    check({tag, "_busy_cnt"}, 160'(busy_cnt), 160'd81);
    check({tag, "_idx_seq"},  160'(idx_bad),  160'd0);
    check({tag, "_idle_idx"}, {153'd0, bus.loop_idx}, 160'd0);
    check({tag, "_panic"},    {159'd0, bus.panic}, {159'd0, (inject_at >= 0)});
    dg = bus.digest;
  endtask

  task automatic wait_idx(input int n, input string tag);
    int k = 0;
    while (!(bus.busy && bus.loop_idx == 7'(n)) && k < 200) begin
      @(negedge wb_clk_i);
      k++;
    end
    check(tag, {153'd0, bus.loop_idx}, 160'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [8];
    logic [511:0] m, b1, b2, ma;
    logic [159:0] dg, cur;

    bus.start = 1'b0; bus.chain = 1'b0; bus.abort = 1'b0; bus.message = '0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_digest", bus.digest, 160'd0);
    check("rst_done",   {159'd0, bus.done},  160'd0);
    check("rst_busy",   {159'd0, bus.busy},  160'd0);
    check("rst_panic",  {159'd0, bus.panic}, 160'd0);
    check("rst_idx",    {153'd0, bus.loop_idx}, 160'd0);
    reset_n = 1'b1;

    m = '0; m[31:0] = 32'h61626380; m[511:480] = 32'h00000018;
    tbl[0] = '{m, 1'b0, ABC_D};
    b1 = '0;
    for (int i = 0; i < 14; i++)
      b1[32*i +: 32] = {8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)};
    b1[32*14 +: 32] = 32'h80000000;
    tbl[1] = '{b1, 1'b0, ref_compress(IV_C, b1)};
    b2 = '0; b2[511:480] = 32'h000001c0;
    tbl[2] = '{b2, 1'b1, TWO_D};
    for (int i = 3; i < 8; i++) begin
      tbl[i].msg   = rand_msg();
      tbl[i].chain = 1'($urandom_range(0, 1));
      tbl[i].exp   = ref_compress(tbl[i].chain ? tbl[i-1].exp : IV_C, tbl[i].msg);
    end

    for (int i = 0; i < 8; i++) begin
      run_block(tbl[i].msg, tbl[i].chain, -1, $sformatf("vec%0d", i), dg);
      check($sformatf("vec%0d_digest", i), dg, tbl[i].exp);
    end
    cur = tbl[7].exp;

    // Stray start mid-computation: flagged, otherwise harmless.
    run_block(tbl[0].msg, 1'b0, 40, "panic", dg);
    check("panic_digest", dg, ABC_D);
    ma = rand_msg();
    run_block(ma, 1'b1, -1, "after_panic", dg);
    cur = ref_compress(ABC_D, ma);
    check("after_panic_digest", dg, cur);

    // Abort mid-round (with a coincident start that must lose).
    @(negedge wb_clk_i);
    bus.message = rand_msg(); bus.chain = 1'b0; bus.start = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    wait_idx(10, "abort_w10");
    bus.start = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    check("abort_pre_panic", {159'd0, bus.panic}, 160'd1);
    wait_idx(20, "abort_w20");
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_busy",   {159'd0, bus.busy},  160'd0);
    check("abort_done",   {159'd0, bus.done},  160'd0);
    check("abort_panic",  {159'd0, bus.panic}, 160'd0);
    check("abort_idx",    {153'd0, bus.loop_idx}, 160'd0);
    check("abort_digest", bus.digest, cur);
    repeat (3) @(negedge wb_clk_i);
    check("abort_stay_idle", {159'd0, bus.busy}, 160'd0);
    ma = rand_msg();
    run_block(ma, 1'b1, -1, "after_abort", dg);
    cur = ref_compress(cur, ma);
    check("after_abort_digest", dg, cur);

    // Synchronous reset mid-round while start is held high.
    @(negedge wb_clk_i);
    bus.message = rand_msg(); bus.chain = 1'b1; bus.start = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    wait_idx(30, "rst_w30");
    reset_n = 1'b0; bus.start = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_digest", bus.digest, 160'd0);
    check("midrst_busy",   {159'd0, bus.busy},  160'd0);
    check("midrst_done",   {159'd0, bus.done},  160'd0);
    check("midrst_idx",    {153'd0, bus.loop_idx}, 160'd0);
    @(negedge wb_clk_i);
    check("midrst_hold_busy", {159'd0, bus.busy}, 160'd0);
    reset_n = 1'b1; bus.start = 1'b0;
    @(negedge wb_clk_i);
    check("postrst_busy", {159'd0, bus.busy}, 160'd0);
    check("postrst_idx",  {153'd0, bus.loop_idx}, 160'd0);
    // Chaining straight after reset uses the cleared digest as H.
    ma = rand_msg();
    run_block(ma, 1'b1, -1, "postrst_chain", dg);
    check("postrst_chain_digest", dg, ref_compress(160'd0, ma));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
